// File: rtl/uart_tx_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_drain                                                   |
// | Purpose  : Pops bytes from the cipher FIFO and sends them as UART frames.  |
// |            Optional even parity bit when UART_TX_PARITY_EN is defined.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_SIZE    = 8
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy,
  output logic                 byte_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  c_bit_last  = BIT_W'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t               r_state, w_state_next;
  logic                 r_tx, w_tx_next;
  logic                 r_fifo_read, w_fifo_read_next;
  logic [DATA_SIZE-1:0] r_shreg, w_shreg_next;
  logic [DATA_SIZE-1:0] w_shifted;
  logic [BAUD_W-1:0]    r_baud, w_baud_next;
  logic [BIT_W-1:0]     r_bit, w_bit_next;
  logic                 w_baud_end;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity, w_parity_next;
`endif

  assign w_baud_end = (r_baud == c_baud_last);
  assign w_shifted  = r_shreg >> 1;

  always_comb begin
    w_state_next     = r_state;
    w_tx_next        = r_tx;
    w_fifo_read_next = 1'b0;
    w_shreg_next     = r_shreg;
    w_bit_next       = r_bit;
    w_baud_next      = w_baud_end ? '0 : r_baud + 1'b1;
`ifdef UART_TX_PARITY_EN
    w_parity_next    = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        w_tx_next   = 1'b1;
        if (!fifo_empty) begin
          w_shreg_next  = fifo_data;
          w_bit_next    = '0;
          w_tx_next     = 1'b0;
          w_state_next  = S_START;
`ifdef UART_TX_PARITY_EN
          w_parity_next = 1'b0;
`endif
        end
      end
      S_START: begin
        // Pop lands in the second START cycle, so the FIFO head settles long before IDLE.
        w_fifo_read_next = (r_baud == '0);
        if (w_baud_end) begin
          w_tx_next    = r_shreg[0];
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_shreg_next  = w_shifted;
`ifdef UART_TX_PARITY_EN
          w_parity_next = r_parity ^ r_shreg[0];
`endif
          if (r_bit == c_bit_last) begin
`ifdef UART_TX_PARITY_EN
            w_tx_next    = r_parity ^ r_shreg[0];
            w_state_next = S_PARITY;
`else
            w_tx_next    = 1'b1;
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_next = r_bit + 1'b1;
            w_tx_next  = w_shifted[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) begin
          w_tx_next    = 1'b1;
          w_state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_end) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
        w_baud_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tx        <= 1'b1;
      r_fifo_read <= 1'b0;
      r_shreg     <= '0;
      r_baud      <= '0;
      r_bit       <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_tx        <= w_tx_next;
      r_fifo_read <= w_fifo_read_next;
      r_shreg     <= w_shreg_next;
      r_baud      <= w_baud_next;
      r_bit       <= w_bit_next;
`ifdef UART_TX_PARITY_EN
      r_parity    <= w_parity_next;
`endif
    end
  end

  assign tx        = r_tx;
  assign fifo_read = r_fifo_read;
  assign busy      = (r_state != S_IDLE);
  assign byte_done = (r_state == S_STOP) && w_baud_end;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_drain                                                |
// | Purpose  : Randomised bench for uart_tx_drain with a FIFO and line model.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uart_tx_drain;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic       clk_100MHz = 1'b0;
  logic       reset;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read, tx, busy, byte_done;

  uart_tx_drain #(.CLKS_PER_BIT(C), .DATA_SIZE(8)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .tx         (tx),
    .busy       (busy),
    .byte_done  (byte_done)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int checks = 0;
  int errors = 0;
  int reads, dones, busy_cycles, frames_done, cyc;
  int mon_pos = -1;
  logic prev_tx = 1'b1;
  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  int          starts[$];
  logic [7:0]  mon_exp, mon_rx;
  logic [10:0] mon_bits;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line image of one frame, index 0 = start bit.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ($countones(b) % 2) == 1;
`endif
    return f;
  endfunction

  always @(negedge clk_100MHz) begin
    cyc++;
    if (reset) begin
      mon_pos = -1;
    end else begin
      if (mon_pos < 0 && prev_tx && !tx) begin
        check("exp_available", exp_q.size() > 0, 1);
        mon_exp  = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        mon_bits = frame_bits(mon_exp);
        mon_pos  = 0;
        starts.push_back(cyc);
      end
      if (mon_pos >= 0) begin
        check("tx_bit", tx, mon_bits[mon_pos / C]);
        check("busy_frame", busy, 1);
        check("fifo_read_pos", fifo_read, mon_pos == 1);
        check("byte_done_pos", byte_done, mon_pos == FRAME*C - 1);
        if ((mon_pos % C) == C/2 && (mon_pos / C) >= 1 && (mon_pos / C) <= 8)
          mon_rx[(mon_pos / C) - 1] = tx;
        mon_pos++;
        if (mon_pos == FRAME*C) begin
          check("rx_byte", mon_rx, mon_exp);
          frames_done++;
          mon_pos = -1;
        end
      end else begin
        check("tx_idle", tx, 1);
        check("busy_idle", busy, 0);
        check("fifo_read_idle", fifo_read, 0);
      end
    end
    prev_tx = tx;
  end

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'($urandom) : fifo_q[0];
  endtask

  task automatic tick();
    logic rd;
    @(negedge clk_100MHz);
    rd = fifo_read;
    if (fifo_read) reads++;
    if (byte_done) dones++;
    if (busy)      busy_cycles++;
    @(posedge clk_100MHz);
    if (rd && fifo_q.size() > 0) fifo_q.delete(0);
    #1 drive_fifo();
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    drive_fifo();
  endtask

  task automatic clear_counts();
    reads = 0; dones = 0; busy_cycles = 0;
    starts.delete();
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || mon_pos >= 0 || busy) && n < limit) begin
      tick();
      n++;
    end
    check("idle_reached", n < limit, 1);
    repeat (3) tick();
  endtask

  initial begin
    logic [7:0] hello[8];
    int frames0, n;
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21, 8'h21, 8'h21};
    reset = 1'b1; fifo_empty = 1'b1; fifo_data = 8'h00;
    repeat (3) @(negedge clk_100MHz);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_byte_done", byte_done, 0);
    @(posedge clk_100MHz); #1 reset = 1'b0;
    repeat (2) tick();

    // Single byte
    clear_counts();
    push(8'h53);
    wait_idle(200);
    check("single_reads", reads, 1);
    check("single_dones", dones, 1);
    check("single_busy_len", busy_cycles, FRAME*C);

    // Full drain of HELLO!!!
    clear_counts();
    frames0 = frames_done;
    foreach (hello[i]) push(hello[i]);
    wait_idle(1000);
    check("drain_reads", reads, 8);
    check("drain_frames", frames_done - frames0, 8);
    check("drain_starts", starts.size(), 8);
    for (int i = 1; i < starts.size(); i++)
      check("drain_spacing", starts[i] - starts[i-1], FRAME*C + 1);
    check("drain_empty", fifo_empty, 1);

    // Empty hold-off with toggling data
    clear_counts();
    repeat (500) tick();
    check("holdoff_reads", reads, 0);
    check("holdoff_busy", busy_cycles, 0);

    // Head changes during START
    frames0 = frames_done;
    push(8'hAA);
    n = 0;
    while (tx !== 1'b0 && n < 20) begin tick(); n++; end
    check("start_seen", tx, 0);
    fifo_q[0] = 8'h55;
    drive_fifo();
    wait_idle(200);
    check("midchange_frames", frames_done - frames0, 1);

    // Reset during data bit 3
    push(8'h3C);
    n = 0;
    while (mon_pos < 4*C + 2 && n < 100) begin tick(); n++; end
    check("bit3_reached", mon_pos >= 4*C + 2, 1);
    reset = 1'b1;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_fifo_read", fifo_read, 0);
    repeat (3) tick();
    reset = 1'b0;
    frames0 = frames_done;
    push(8'hC3);
    wait_idle(200);
    check("post_reset_frames", frames_done - frames0, 1);

    // Parity-sensitive pair
    clear_counts();
    push(8'h53);
    push(8'h07);
    wait_idle(300);
    check("pair_reads", reads, 2);
    check("pair_busy_len", busy_cycles, 2*FRAME*C);

    // Random traffic
    clear_counts();
    frames0 = frames_done;
    for (int i = 0; i < 25; i++) begin
      push(8'($urandom));
      repeat ($urandom_range(0, 50)) tick();
    end
    wait_idle(5000);
    check("rand_frames", frames_done - frames0, 25);
    check("rand_reads", reads, 25);
    check("rand_dones", dones, 25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_drain.md
# uart_tx_drain

UART transmit stage that drains the byte FIFO downstream of the cipher. Whenever the FIFO reports non-empty, it pops one byte, serialises it as an 8N1 frame (optionally 8E1) on the `tx` line at a fixed baud rate, and repeats until the FIFO is empty. It connects directly to the FIFO's `read_data_out`, `empty` and `read_from_fifo` signals.

## Interface
- `CLKS_PER_BIT`, default 10417: clock cycles per UART bit (100 MHz / 9600 baud, rounded). Must be ≥ 2.
- `DATA_SIZE`, default 8: bits per character. Matches the FIFO word width.

- `clk_100MHz`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `fifo_empty`  in  1  FIFO empty flag. When low, `fifo_data` is valid.
- `fifo_data`  in  DATA_SIZE  current FIFO head byte. Combinational from the FIFO.
- `fifo_read`  out  1  one-cycle pop pulse, wired to the FIFO's `read_from_fifo`.
- `tx`  out  1  serial line. Idle high. Registered.
- `busy`  out  1  high while a frame is in progress (any state other than IDLE).
- `byte_done`  out  1  one-cycle pulse in the final cycle of the stop bit.

## Operation
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP.
- **IDLE:** `tx`=1.
  - On an edge where `fifo_empty`=0: load `shreg`←`fifo_data`, clear the parity accumulator, set bit counter=0 and baud counter=0, set `tx`←0, go to START.
  - `fifo_read` is registered and goes high for exactly the one cycle after that capture edge. The FIFO then advances its pointer on the next edge.
- **START:** hold `tx`=0 for `CLKS_PER_BIT` cycles. At the end, `tx`←`shreg[0]` and go to DATA.
- **DATA:** LSB first. Each bit is held `CLKS_PER_BIT` cycles. At each bit end, `shreg` shifts right, and parity XORs in the bit just sent.
  - After bit `DATA_SIZE-1`, go to PARITY, or to STOP with `tx`←1.
- **STOP:** hold `tx`=1 for `CLKS_PER_BIT` cycles. `byte_done`=1 in the last cycle. Then go to IDLE.
- **Counter widths:**
  - Baud counter is `$clog2(CLKS_PER_BIT)` bits and counts 0..`CLKS_PER_BIT`-1. The bit ends when the count reaches `CLKS_PER_BIT`-1.
  - Bit counter is `$clog2(DATA_SIZE)` bits and counts 0..`DATA_SIZE`-1. No wrap past `DATA_SIZE`-1.
- **Input sampling:** `fifo_empty` and `fifo_data` are ignored outside IDLE. FIFO writes mid-frame do not corrupt the byte in flight, because it is held in `shreg`.
- **Last byte:** the FIFO raises `empty` on the pop that wraps its pointer to 0. The block then sits in IDLE until the next FIFO write clears `empty`.
- **Reset (asynchronous, any state including mid-frame):**
  - State=IDLE, `tx`=1, `fifo_read`=0, `busy`=0, `byte_done`=0, counters=0, `shreg`=0.
  - A truncated frame is simply abandoned. No glitch low on `tx`.

## Timing
- **Start latency:** `fifo_empty` falls before edge N, with the FSM in IDLE. `tx` falls after edge N and `busy` rises after edge N. `fifo_read` is high from edge N+1 to edge N+2.
- **Frame length:** 10·`CLKS_PER_BIT` cycles (8N1), or 11·`CLKS_PER_BIT` with parity.
- **Back-to-back frames:** exactly one IDLE cycle separates frames. Start-to-start spacing is 10·`CLKS_PER_BIT`+1 cycles.
  - Draining 8 bytes takes 8·(10·`CLKS_PER_BIT`+1) cycles.
- **FIFO settling:** the FIFO head is stable well before the next IDLE, since the pop occurs in the second cycle of START.
- **Reset release:** no frame starts before the first rising edge after `reset` deasserts.

## Configuration
- Macro `UART_TX_PARITY_EN`.
  - **Defined:** the PARITY state is compiled in. After the last data bit, `tx` carries even parity (XOR of all data bits) for `CLKS_PER_BIT` cycles, then STOP. Frame is 11 bits.
  - **Undefined:** the PARITY state and the accumulator are absent. DATA goes straight to STOP. Frame is 10 bits, 8N1.

## Test plan
- **Single byte:** `CLKS_PER_BIT`=4, FIFO holds 0x53, `fifo_empty` drops.
  - `tx` sequence per 4 cycles: 0,1,1,0,0,1,0,1,0,1.
  - One `fifo_read` pulse, one `byte_done`, `busy` high for 40 cycles.
- **Full drain:** `CLKS_PER_BIT`=4, 64-bit word 0x48454C4C4F212121 written.
  - Bytes 'H','E','L','L','O','!','!','!' decoded in order.
  - Exactly 8 `fifo_read` pulses, starts spaced 41 cycles apart.
  - Block returns to IDLE with `fifo_empty`=1.
- **Empty hold-off:** `fifo_empty`=1 for 500 cycles with `fifo_data` toggling.
  - `tx`=1, `fifo_read`=0 and `busy`=0 throughout.
- **Reset mid-frame:** assert `reset` during DATA bit 3.
  - Same cycle: `tx`=1, `busy`=0, `fifo_read`=0.
  - After release with the FIFO non-empty, the next frame is a complete, valid frame.
- **Data change mid-frame:** `fifo_data` changes from 0xAA to 0x55 during START.
  - Transmitted byte is 0xAA.
- **Parity build** (`UART_TX_PARITY_EN` defined): bytes 0x53 then 0x07.
  - Parity bits 0 then 1, frame length 44 cycles.
